// File: rtl/fp_alu_pkg.sv
// Shared widths and types for the fp_alu datapath.
// Holds the default mantissa/exponent widths and the normalizer state encoding.
package fp_alu_pkg;

  localparam int MANT_W_DEF = 16;
  localparam int EXP_W_DEF  = 5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } norm_state_t;

endpackage

// File: rtl/fp_lzc.sv
// Parameterized leading-zero counter; all-zero input returns W.
// Only compiled when FP_NORM_FAST_LZD_EN is defined (single-cycle normalize path).
`ifdef FP_NORM_FAST_LZD_EN
module fp_lzc #(
  parameter  int W  = 16,
  localparam int CW = $clog2(W),
  localparam int OW = CW + 1
) (
  input  logic [W-1:0] i_data,
  output logic [OW-1:0] o_count
);

  always_comb begin
    // NOTE: default assigned before the loop so every path drives o_count and no latch is inferred.
    o_count = OW'(W);
    for (int i = 0; i < W; i++) begin
      if (i_data[i]) o_count = OW'(W - 1 - i);
    end
  end

endmodule
`endif

// File: rtl/fp_normalizer.sv
// Post-add/sub mantissa normalizer with valid/ready on both sides.
// Define FP_NORM_FAST_LZD_EN for a single-cycle barrel-shift normalize; default is one bit per cycle.
module fp_normalizer
  import fp_alu_pkg::*;
#(
  parameter  int MANT_W = MANT_W_DEF,
  parameter  int EXP_W  = EXP_W_DEF,
  localparam int CNT_W  = $clog2(MANT_W)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [MANT_W-1:0] in_mant,
  input  logic [EXP_W-1:0]  in_exp,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [MANT_W-1:0] out_mant,
  output logic [EXP_W-1:0]  out_exp,
  output logic [CNT_W-1:0]  out_shift,
  output logic              out_zero,
  output logic              out_uflow
);

  norm_state_t       r_state;
  logic              r_in_ready;
  logic              r_out_valid;
  logic [MANT_W-1:0] r_mant;
  logic [EXP_W-1:0]  r_exp;
  logic [CNT_W-1:0]  r_shift;
  logic              r_zero;
  logic              r_uflow;

  logic w_accept;
  logic w_handoff;

  assign w_accept  = in_valid & r_in_ready;
  assign w_handoff = r_out_valid & out_ready;

`ifdef FP_NORM_FAST_LZD_EN
  logic [CNT_W:0]   w_lzc;
  logic [CNT_W-1:0] w_sh;
  logic             w_uflow;

  fp_lzc #(.W(MANT_W)) u_lzc (
    .i_data  (r_mant),
    .o_count (w_lzc)
  );

  // Clamp the shift at the exponent so it bottoms out at 0 instead of wrapping.
  always_comb begin
    if (int'(w_lzc) > int'(r_exp)) begin
      w_sh    = CNT_W'(r_exp);
      w_uflow = (r_mant != '0);
    end else begin
      w_sh    = CNT_W'(w_lzc);
      w_uflow = 1'b0;
    end
  end
`endif

  // NOTE: all state uses non-blocking assignments so each flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_mant      <= '0;
      r_exp       <= '0;
      r_shift     <= '0;
      r_zero      <= 1'b0;
      r_uflow     <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_in_ready <= 1'b1;
          if (w_accept) begin
            r_mant     <= in_mant;
            r_exp      <= in_exp;
            r_shift    <= '0;
            r_zero     <= 1'b0;
            r_uflow    <= 1'b0;
            r_in_ready <= 1'b0;
            r_state    <= SHIFT;
          end
        end

        SHIFT: begin
          if (r_mant == '0) begin
            r_zero  <= 1'b1;
            r_exp   <= '0;
            r_shift <= '0;
            r_state <= DONE;
          end else begin
`ifdef FP_NORM_FAST_LZD_EN
            r_mant  <= r_mant << w_sh;
            r_exp   <= r_exp - EXP_W'(w_sh);
            r_shift <= w_sh;
            r_uflow <= w_uflow;
            r_state <= DONE;
`else
            if (r_mant[MANT_W-1]) begin
              r_state <= DONE;
            end else if (r_exp == '0) begin
              r_uflow <= 1'b1;
              r_state <= DONE;
            end else begin
              r_mant  <= {r_mant[MANT_W-2:0], 1'b0};
              r_exp   <= r_exp - EXP_W'(1);
              r_shift <= r_shift + CNT_W'(1);
            end
`endif
          end
        end

        DONE: begin
          // Valid is raised one edge after entering DONE, giving the k+2 edge latency.
          if (w_handoff) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= IDLE;
          end else begin
            r_out_valid <= 1'b1;
          end
        end

        default: r_state <= IDLE;
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_mant  = r_mant;
  assign out_exp   = r_exp;
  assign out_shift = r_shift;
  assign out_zero  = r_zero;
  assign out_uflow = r_uflow;

endmodule

// File: tb/tb_fp_normalizer.sv
// Self-checking bench for fp_normalizer: directed cases with literal results, then random traffic
// checked every valid cycle against a leading-zero/min-based reference model.
module tb_fp_normalizer;

`ifdef FP_NORM_FAST_LZD_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_mant;
  logic [4:0]  in_exp;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_mant;
  logic [4:0]  out_exp;
  logic [3:0]  out_shift;
  logic        out_zero;
  logic        out_uflow;

  fp_normalizer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_mant   (in_mant),
    .in_exp    (in_exp),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_mant  (out_mant),
    .out_exp   (out_exp),
    .out_shift (out_shift),
    .out_zero  (out_zero),
    .out_uflow (out_uflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] mant;
    logic [4:0]  exp;
    logic [3:0]  shift;
    logic        zero;
    logic        uflow;
    int          rise;
  } exp_t;

  exp_t expq[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  bit   rand_ready = 1'b0;
  bit   prev_valid = 1'b0;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    n_checks++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h want 0x%0h (cycle %0d)", name, act, want, cyc);
    end
  endtask

  // Reference: shift by leading zeros, clamped by the exponent.
  function automatic exp_t model(input logic [15:0] m, input logic [4:0] e, input int acc);
    exp_t r;
    int   lz = 0;
    int   s;
    while (lz < 16 && !m[15 - lz]) lz++;
    if (m == 16'h0) begin
      r.mant = 16'h0; r.exp = 5'd0; r.shift = 4'd0; r.zero = 1'b1; r.uflow = 1'b0;
      r.rise = acc + 2;
    end else begin
      s = (lz < int'(e)) ? lz : int'(e);
      r.mant  = m << s;
      r.exp   = 5'(int'(e) - s);
      r.shift = 4'(s);
      r.zero  = 1'b0;
      r.uflow = (lz > int'(e));
      r.rise  = acc + (FAST ? 2 : s + 2);
    end
    return r;
  endfunction

  // Compare process: every valid cycle, outputs must equal the head of the expected queue.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_valid = 1'b0;
    end else begin
      if (out_valid) begin
        if (expq.size() == 0) begin
          check("unexpected_out_valid", 32'(out_valid), 32'd0);
        end else begin
          if (!prev_valid) check("rise_cycle", cyc, expq[0].rise);
          check("mant",  out_mant,  expq[0].mant);
          check("exp",   out_exp,   expq[0].exp);
          check("shift", out_shift, expq[0].shift);
          check("zero",  out_zero,  expq[0].zero);
          check("uflow", out_uflow, expq[0].uflow);
          check("in_ready_while_valid", in_ready, 32'd0);
          if (out_ready) void'(expq.pop_front());
        end
      end
      prev_valid = out_valid;
    end
  end

  always @(posedge clk) begin
    if (rand_ready) begin
      #1 out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // Call at posedge+1; returns at the posedge+1 following the accept edge.
  task automatic send(input logic [15:0] m, input logic [4:0] e, output int acc);
    int budget = 0;
    in_mant  = m;
    in_exp   = e;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && budget < 100) begin
      @(negedge clk);
      budget++;
    end
    if (!in_ready) begin
      check("accept_timeout", 32'd0, 32'd1);
      acc = -1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      return;
    end
    acc = cyc + 1;
    expq.push_back(model(m, e, acc));
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_mant  = 16'($urandom);
    in_exp   = 5'($urandom);
  endtask

  task automatic expect_lit(input int acc, input int lat, input logic [15:0] m, input logic [4:0] e,
                            input logic [3:0] sh, input logic z, input logic u, input bit release_it);
    int budget = 0;
    @(negedge clk);
    while (!out_valid && budget < 40) begin
      @(negedge clk);
      budget++;
    end
    check("lit_latency", cyc - acc, lat);
    check("lit_mant",  out_mant,  m);
    check("lit_exp",   out_exp,   e);
    check("lit_shift", out_shift, sh);
    check("lit_zero",  out_zero,  z);
    check("lit_uflow", out_uflow, u);
    if (release_it) begin
      @(posedge clk); #1 out_ready = 1'b1;
      @(posedge clk); #1 out_ready = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] m;
    logic [4:0]  e;
    int          acc;
    int          budget;

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_mant = '0; in_exp = '0;
    @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready",  in_ready,  0);
    check("rst_mant",      out_mant,  0);
    check("rst_exp",       out_exp,   0);
    check("rst_shift",     out_shift, 0);
    check("rst_zero",      out_zero,  0);
    check("rst_uflow",     out_uflow, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("in_ready_before_first_edge", in_ready, 0);
    @(negedge clk);
    check("in_ready_after_first_edge", in_ready, 1);
    @(posedge clk); #1;

    send(16'h8000, 5'd10, acc); expect_lit(acc, 2, 16'h8000, 5'd10, 4'd0, 0, 0, 1);
    send(16'h0001, 5'd20, acc); expect_lit(acc, FAST ? 2 : 17, 16'h8000, 5'd5, 4'd15, 0, 0, 1);
    send(16'h0010, 5'd3, acc);  expect_lit(acc, FAST ? 2 : 5, 16'h0080, 5'd0, 4'd3, 0, 1, 1);
    send(16'h0000, 5'd12, acc); expect_lit(acc, 2, 16'h0000, 5'd0, 4'd0, 1, 0, 1);

    // Backpressure: result held while a new input waits.
    @(posedge clk); #1;
    send(16'h00F0, 5'd9, acc); expect_lit(acc, FAST ? 2 : 10, 16'hF000, 5'd1, 4'd8, 0, 0, 0);
    @(posedge clk); #1;
    in_valid = 1'b1; in_mant = 16'h4000; in_exp = 5'd7;
    repeat (5) begin
      @(negedge clk);
      check("pending_in_ready", in_ready, 0);
      check("pending_valid", out_valid, 1);
    end
    @(posedge clk); #1 out_ready = 1'b1;
    @(posedge clk); #1 out_ready = 1'b0;
    send(16'h4000, 5'd7, acc); expect_lit(acc, FAST ? 2 : 3, 16'h8000, 5'd6, 4'd1, 0, 0, 1);

    // Reset during SHIFT discards the in-flight item.
    @(posedge clk); #1;
    send(16'h0001, 5'd20, acc);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk); #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_in_ready",  in_ready,  0);
    check("midrst_mant",      out_mant,  0);
    check("midrst_exp",       out_exp,   0);
    check("midrst_shift",     out_shift, 0);
    check("midrst_zero",      out_zero,  0);
    check("midrst_uflow",     out_uflow, 0);
    rst_n = 1'b1;
    expq.delete();
    @(negedge clk);
    check("midrst_in_ready_low", in_ready, 0);
    @(negedge clk);
    check("midrst_in_ready_high", in_ready, 1);
    repeat (25) @(negedge clk);
    check("no_stale_result", out_valid, 0);

    // Random traffic with random backpressure.
    @(posedge clk); #1;
    rand_ready = 1'b1;
    for (int t = 0; t < 40; t++) begin
      m = 16'($urandom) >> $urandom_range(0, 16);
      if ($urandom_range(0, 9) == 0) m = 16'h0;
      e = 5'($urandom);
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
      end
      send(m, e, acc);
    end
    budget = 0;
    while (expq.size() > 0 && budget < 300) begin
      @(negedge clk);
      budget++;
    end
    check("drain", expq.size(), 0);
    rand_ready = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
